// File: rtl/vga_pkg.sv
// vga_pkg: shared constants and types for the VGA test-pattern generator.
//   - 640x480 visible-area constants
//   - pattern-mode and bounce-axis state encodings
//   - pipeline control payload carried alongside the colour
//   - 8-entry colour-bar table
package vga_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned COORD_W  = 10;
  localparam int unsigned RGB_W    = 12;
  localparam int unsigned NUM_BARS = 8;

  typedef enum logic [1:0] {
    MODE_SOLID   = 2'd0,
    MODE_BARS    = 2'd1,
    MODE_CHECKER = 2'd2,
    MODE_BOX     = 2'd3
  } mode_e;

  typedef enum logic {
    AXIS_INC = 1'b0,
    AXIS_DEC = 1'b1
  } axis_state_e;

  // Sync/blank bits that travel with the pixel through the pipeline
  typedef struct packed {
    logic disp;
    logic hsync;
    logic vsync;
  } pix_ctl_t;

  // Colour-bar table, left to right
  function automatic logic [RGB_W-1:0] bar_colour(input logic [2:0] idx);
    logic [RGB_W-1:0] c;
    case (idx)
      3'd0:    c = 12'h000;
      3'd1:    c = 12'h00f;
      3'd2:    c = 12'h0f0;
      3'd3:    c = 12'h0ff;
      3'd4:    c = 12'hf00;
      3'd5:    c = 12'hf0f;
      3'd6:    c = 12'hff0;
      default: c = 12'hfff;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_bounce_axis.sv
// vga_bounce_axis: one axis of the bouncing box. Position walks between 0 and
// LIMIT by STEP per tick, reversing direction at either end.
// Ports:
//   clk, rstn  - clock, async active-low reset
//   tick_i     - one-cycle frame tick, advances the position
//   pos_o      - current position (0..LIMIT)
//   dir_o      - current direction (0 = increasing, 1 = decreasing)
module vga_bounce_axis #(
  parameter int unsigned LIMIT = 608,
  parameter int unsigned STEP  = 1,
  parameter int unsigned W     = 10
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         tick_i,
  output logic [W-1:0] pos_o,
  output logic         dir_o
);
  import vga_pkg::*;

  axis_state_e  state_q, state_d;
  logic [W-1:0] pos_q, pos_d;

  // State and position register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= AXIS_INC;
      pos_q   <= '0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
    end
  end

  // Next state: step toward the current end, reverse once the end is reached
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    if (tick_i) begin
      unique case (state_q)
        AXIS_INC: begin
          if (32'(pos_q) + STEP > LIMIT) begin
            state_d = AXIS_DEC;
            pos_d   = W'(LIMIT - STEP);
          end else begin
            pos_d = pos_q + W'(STEP);
          end
        end
        AXIS_DEC: begin
          if (32'(pos_q) < STEP) begin
            state_d = AXIS_INC;
            pos_d   = W'(STEP);
          end else begin
            pos_d = pos_q - W'(STEP);
          end
        end
        default: begin
          state_d = AXIS_INC;
          pos_d   = '0;
        end
      endcase
    end
  end

  assign pos_o = pos_q;
  assign dir_o = state_q;

endmodule

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: test-pattern generator behind a VGA timing generator.
// Two-stage pipeline: stage 1 looks up the pattern colour, stage 2 blanks it
// outside the visible area. Syncs are delayed to stay aligned with rgb.
// Ports:
//   clk, rstn      - pixel clock, async active-low reset
//   hsync_in       - active-low hsync from timing generator
//   vsync_in       - active-low vsync from timing generator
//   displaying_in  - high while x/y are visible
//   x, y           - current pixel column / row
//   mode           - requested pattern (0 solid, 1 bars, 2 checker, 3 box)
//   hsync, vsync   - syncs delayed by 2 clocks
//   rgb            - 4:4:4 colour, 0 outside the visible area
module vga_pattern_gen #(
  parameter int unsigned H_ACTIVE  = vga_pkg::H_ACTIVE,
  parameter int unsigned V_ACTIVE  = vga_pkg::V_ACTIVE,
  parameter int unsigned BOX       = 32,
  parameter logic [11:0] SOLID_RGB = 12'hf0f
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        displaying_in,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic [1:0]  mode,
  output logic        hsync,
  output logic        vsync,
  output logic [11:0] rgb
);
  import vga_pkg::*;

  localparam int unsigned BAR_W     = H_ACTIVE / NUM_BARS;
  localparam bit          BAR_POW2  = ((BAR_W & (BAR_W - 1)) == 0);
  localparam int unsigned BAR_SH    = $clog2(BAR_W);
  localparam bit          BOX_POW2  = ((BOX & (BOX - 1)) == 0);
  localparam int unsigned BOX_SH    = $clog2(BOX);
  localparam int unsigned CELLS_MAX = 1023 / BOX;
  localparam int unsigned BX_LIMIT  = H_ACTIVE - BOX;
  localparam int unsigned BY_LIMIT  = V_ACTIVE - BOX;

  logic             vs_hist_q;
  logic             frame_tick_c;
  mode_e            mode_q, mode_d;
  logic [RGB_W-1:0] col_q, col_d;
  pix_ctl_t         ctl1_q, ctl1_d;
  logic [RGB_W-1:0] rgb_q, rgb_d;
  logic             hsync_q, vsync_q;

  logic [COORD_W-1:0] bx_w, by_w;
  logic               bx_dir_w, by_dir_w;

  logic [2:0]         bar_idx_c;
  logic               chk_odd_c;
  logic               box_hit_c;
  logic [COORD_W-1:0] cx_c, cy_c;

  // End of the vsync pulse: previous sample low, current sample high
  assign frame_tick_c = ~vs_hist_q & vsync_in;

  vga_bounce_axis #(
    .LIMIT (BX_LIMIT),
    .STEP  (1),
    .W     (COORD_W)
  ) u_axis_x (
    .clk    (clk),
    .rstn   (rstn),
    .tick_i (frame_tick_c),
    .pos_o  (bx_w),
    .dir_o  (bx_dir_w)
  );

  vga_bounce_axis #(
    .LIMIT (BY_LIMIT),
    .STEP  (1),
    .W     (COORD_W)
  ) u_axis_y (
    .clk    (clk),
    .rstn   (rstn),
    .tick_i (frame_tick_c),
    .pos_o  (by_w),
    .dir_o  (by_dir_w)
  );

  // Bar index, saturating at the last bar for columns past the visible area
  always_comb begin
    bar_idx_c = 3'd7;
    if (BAR_POW2) begin
      if ((x >> BAR_SH) < 10'd7) begin
        bar_idx_c = 3'(x >> BAR_SH);
      end
    end else begin
      for (int unsigned k = 7; k > 0; k--) begin
        if (32'(x) < k * BAR_W) begin
          bar_idx_c = 3'(k - 1);
        end
      end
    end
  end

  // Checker cell parity: lsb of (x/BOX xor y/BOX)
  always_comb begin
    cx_c      = x >> BOX_SH;
    cy_c      = y >> BOX_SH;
    chk_odd_c = cx_c[0] ^ cy_c[0];
    if (!BOX_POW2) begin
      chk_odd_c = 1'b0;
      for (int unsigned k = 1; k <= CELLS_MAX; k++) begin
        if (32'(x) >= k * BOX) chk_odd_c = ~chk_odd_c;
        if (32'(y) >= k * BOX) chk_odd_c = ~chk_odd_c;
      end
    end
  end

  // Box membership, compared at 11 bits so bx+BOX cannot wrap
  always_comb begin
    box_hit_c = (x >= bx_w) && (11'(x) < 11'(bx_w) + 11'(BOX)) &&
                (y >= by_w) && (11'(y) < 11'(by_w) + 11'(BOX));
  end

  // Stage 1: colour lookup from the applied mode; shadow mode reload on tick
  always_comb begin
    mode_d = mode_q;
    if (frame_tick_c) begin
      mode_d = mode_e'(mode);
    end
    col_d = 12'h000;
    unique case (mode_q)
      MODE_SOLID:   col_d = SOLID_RGB;
      MODE_BARS:    col_d = bar_colour(bar_idx_c);
      MODE_CHECKER: col_d = chk_odd_c ? 12'h000 : 12'hfff;
      MODE_BOX:     col_d = box_hit_c ? 12'hfff : 12'h00f;
      default:      col_d = 12'h000;
    endcase
    ctl1_d = '{disp: displaying_in, hsync: hsync_in, vsync: vsync_in};
    // Stage 2: blank using the displaying bit that travelled with this pixel
    rgb_d = ctl1_q.disp ? col_q : 12'h000;
  end

  // Pipeline and control registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vs_hist_q <= 1'b1;
      mode_q    <= MODE_SOLID;
      col_q     <= '0;
      ctl1_q    <= '{disp: 1'b0, hsync: 1'b1, vsync: 1'b1};
      rgb_q     <= '0;
      hsync_q   <= 1'b1;
      vsync_q   <= 1'b1;
    end else begin
      vs_hist_q <= vsync_in;
      mode_q    <= mode_d;
      col_q     <= col_d;
      ctl1_q    <= ctl1_d;
      rgb_q     <= rgb_d;
      hsync_q   <= ctl1_q.hsync;
      vsync_q   <= ctl1_q.vsync;
    end
  end

  assign rgb   = rgb_q;
  assign hsync = hsync_q;
  assign vsync = vsync_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Scoreboard bench for vga_pattern_gen: the driver queues the expected
// output slot for each checked pixel; the monitor pops and compares.
module tb_vga_pattern_gen;
  import vga_pkg::*;

  logic        clk;
  logic        rstn;
  logic        hsync_in;
  logic        vsync_in;
  logic        displaying_in;
  logic [9:0]  x;
  logic [9:0]  y;
  logic [1:0]  mode;
  logic        hsync;
  logic        vsync;
  logic [11:0] rgb;

  vga_pattern_gen dut (
    .clk           (clk),
    .rstn          (rstn),
    .hsync_in      (hsync_in),
    .vsync_in      (vsync_in),
    .displaying_in (displaying_in),
    .x             (x),
    .y             (y),
    .mode          (mode),
    .hsync         (hsync),
    .vsync         (vsync),
    .rgb           (rgb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    string       name;
  } exp_t;

  typedef struct {
    string       name;
    logic [31:0] act;
    logic [31:0] exp;
  } probe_t;

  exp_t   exp_q[$];
  probe_t probe_q[$];
  int     n_cmp  = 0;
  int     n_fail = 0;
  logic [11:0] bars [8];

  // Monitor: sole owner of the counters
  always @(negedge clk) begin
    exp_t   e;
    probe_t p;
    while (probe_q.size() > 0) begin
      p = probe_q.pop_front();
      n_cmp++;
      if (p.act !== p.exp) begin
        n_fail++;
        $display("FAIL %s: got 0x%0h, want 0x%0h", p.name, p.act, p.exp);
      end
    end
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      n_cmp++;
      n_fail++;
      $display("FAIL %s: output slot missed (due cycle %0d, now %0d)", e.name, e.cyc, cyc);
    end
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (rgb !== e.rgb || hsync !== e.hs || vsync !== e.vs) begin
        n_fail++;
        $display("FAIL %s: got rgb=%h hs=%b vs=%b, want rgb=%h hs=%b vs=%b",
                 e.name, rgb, hsync, vsync, e.rgb, e.hs, e.vs);
      end
    end
  end

  task automatic probe(input string nm, input logic [31:0] act, input logic [31:0] exp);
    probe_t p;
    p.name = nm;
    p.act  = act;
    p.exp  = exp;
    probe_q.push_back(p);
  endtask

  // Apply one pixel for one clock; result is due two clocks later
  task automatic drive(input logic [9:0] px, input logic [9:0] py, input logic d,
                       input logic hs, input logic vs, input logic chk,
                       input logic [11:0] er, input string nm);
    exp_t e;
    x             = px;
    y             = py;
    displaying_in = d;
    hsync_in      = hs;
    vsync_in      = vs;
    if (chk) begin
      e.cyc  = cyc + 2;
      e.rgb  = er;
      e.hs   = hs;
      e.vs   = vs;
      e.name = nm;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  // One vsync pulse: low for a clock, then high (tick at the rising sample)
  task automatic tick();
    drive(10'd0, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000, "");
    drive(10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000, "");
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() > 0 || probe_q.size() > 0) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 50) probe("drain timeout", 32'd1, 32'd0);
  endtask

  initial begin
    bars = '{12'h000, 12'h00f, 12'h0f0, 12'h0ff, 12'hf00, 12'hf0f, 12'hff0, 12'hfff};
    rstn = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1; displaying_in = 1'b0;
    x = '0; y = '0; mode = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    probe("reset outputs", 32'({rgb, hsync, vsync}), 32'({12'h000, 1'b1, 1'b1}));
    probe("reset bx/by", 32'({dut.bx_w, dut.by_w}), 32'd0);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Solid mode, syncs tracking their inputs
    drive(10'd100, 10'd100, 1'b1, 1'b1, 1'b1, 1'b1, 12'hf0f, "solid");
    drive(10'd100, 10'd100, 1'b1, 1'b0, 1'b1, 1'b1, 12'hf0f, "solid hs low");
    drive(10'd5,   10'd7,   1'b1, 1'b1, 1'b0, 1'b1, 12'hf0f, "solid vs low");
    drive(10'd100, 10'd100, 1'b0, 1'b1, 1'b1, 1'b1, 12'h000, "solid blanked");
    drive(10'd100, 10'd100, 1'b1, 1'b1, 1'b1, 1'b1, 12'hf0f, "solid after tick");

    // Mode change 0->1 mid-frame applies only after the vsync rising edge
    mode = 2'd1;
    drive(10'd100, 10'd100, 1'b1, 1'b1, 1'b1, 1'b1, 12'hf0f, "mode pending");
    drive(10'd100, 10'd100, 1'b1, 1'b1, 1'b1, 1'b1, 12'hf0f, "mode pending 2");
    drive(10'd100, 10'd100, 1'b0, 1'b1, 1'b0, 1'b1, 12'h000, "mode vs low");
    drive(10'd100, 10'd100, 1'b1, 1'b1, 1'b1, 1'b1, 12'hf0f, "mode tick edge");
    drive(10'd100, 10'd100, 1'b1, 1'b1, 1'b1, 1'b1, 12'h00f, "mode now bars");

    // Colour bars sweep and saturation
    for (int i = 0; i < 640; i++) begin
      drive(10'(i), 10'd10, 1'b1, 1'b1, 1'b1, 1'b1, bars[i / 80],
            $sformatf("bars x=%0d", i));
    end
    drive(10'd700,  10'd10, 1'b1, 1'b1, 1'b1, 1'b1, 12'hfff, "bars x=700 sat");
    drive(10'd1023, 10'd10, 1'b1, 1'b1, 1'b1, 1'b1, 12'hfff, "bars x=1023 sat");
    drive(10'd100,  10'd10, 1'b0, 1'b1, 1'b1, 1'b1, 12'h000, "bars blanked");

    // Checkerboard
    mode = 2'd2;
    tick();
    drive(10'd0,  10'd0,  1'b1, 1'b1, 1'b1, 1'b1, 12'hfff, "chk 0,0");
    drive(10'd32, 10'd0,  1'b1, 1'b1, 1'b1, 1'b1, 12'h000, "chk 32,0");
    drive(10'd32, 10'd32, 1'b1, 1'b1, 1'b1, 1'b1, 12'hfff, "chk 32,32");
    drive(10'd31, 10'd0,  1'b1, 1'b1, 1'b1, 1'b1, 12'hfff, "chk 31,0");
    drive(10'd63, 10'd64, 1'b1, 1'b1, 1'b1, 1'b1, 12'h000, "chk 63,64");
    drive(10'd32, 10'd0,  1'b0, 1'b1, 1'b1, 1'b1, 12'h000, "chk blanked");

    // Asynchronous reset mid-line
    drive(10'd0, 10'd0, 1'b1, 1'b0, 1'b1, 1'b1, 12'hfff, "pre-reset 1");
    drive(10'd0, 10'd0, 1'b1, 1'b0, 1'b1, 1'b1, 12'hfff, "pre-reset 2");
    drain();
    probe("pre-reset outputs", 32'({rgb, hsync, vsync}), 32'({12'hfff, 1'b0, 1'b1}));
    probe("pre-reset bx", 32'(dut.bx_w), 32'd3);
    #3;
    rstn = 1'b0;
    #1;
    probe("async reset outputs", 32'({rgb, hsync, vsync}), 32'({12'h000, 1'b1, 1'b1}));
    @(posedge clk);
    @(posedge clk);
    #1;
    probe("held reset outputs", 32'({rgb, hsync, vsync}), 32'({12'h000, 1'b1, 1'b1}));
    rstn = 1'b1;
    probe("post-reset state",
          32'({dut.bx_w, dut.by_w, dut.bx_dir_w, dut.by_dir_w, dut.mode_q}), 32'd0);
    @(posedge clk);
    #1;
    drive(10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 12'hf0f, "solid after reset");

    // Bouncing box
    mode = 2'd3;
    tick();
    drive(10'd1,  10'd1,  1'b1, 1'b1, 1'b1, 1'b1, 12'hfff, "box 1,1");
    drive(10'd0,  10'd0,  1'b1, 1'b1, 1'b1, 1'b1, 12'h00f, "box 0,0");
    drive(10'd32, 10'd32, 1'b1, 1'b1, 1'b1, 1'b1, 12'hfff, "box 32,32");
    drive(10'd33, 10'd1,  1'b1, 1'b1, 1'b1, 1'b1, 12'h00f, "box 33,1");
    drive(10'd1,  10'd33, 1'b1, 1'b1, 1'b1, 1'b1, 12'h00f, "box 1,33");
    for (int n = 2; n <= 897; n++) begin
      tick();
      if (n == 448) probe("by at 448", 32'({dut.by_dir_w, dut.by_w}), 32'({AXIS_INC, 10'd448}));
      if (n == 449) probe("by reversed", 32'({dut.by_dir_w, dut.by_w}), 32'({AXIS_DEC, 10'd447}));
      if (n == 608) begin
        probe("bx at 608", 32'({dut.bx_dir_w, dut.bx_w}), 32'({AXIS_INC, 10'd608}));
        drive(10'd608, 10'd288, 1'b1, 1'b1, 1'b1, 1'b1, 12'hfff, "box 608,288");
        drive(10'd607, 10'd288, 1'b1, 1'b1, 1'b1, 1'b1, 12'h00f, "box 607,288");
        drive(10'd639, 10'd319, 1'b1, 1'b1, 1'b1, 1'b1, 12'hfff, "box 639,319");
        drive(10'd608, 10'd320, 1'b1, 1'b1, 1'b1, 1'b1, 12'h00f, "box 608,320");
        drive(10'd639, 10'd319, 1'b0, 1'b1, 1'b1, 1'b1, 12'h000, "box blanked");
      end
      if (n == 609) probe("bx reversed", 32'({dut.bx_dir_w, dut.bx_w}), 32'({AXIS_DEC, 10'd607}));
      if (n == 896) probe("by at 0", 32'({dut.by_dir_w, dut.by_w}), 32'({AXIS_DEC, 10'd0}));
      if (n == 897) begin
        probe("by bounced", 32'({dut.by_dir_w, dut.by_w}), 32'({AXIS_INC, 10'd1}));
        probe("bx at 897", 32'({dut.bx_dir_w, dut.bx_w}), 32'({AXIS_DEC, 10'd319}));
      end
    end

    drain();
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
